// File: rtl/ifu_fetch.sv
// Instruction-fetch front end: keeps the PC, issues one single-beat AXI read at a time
// to the icache and hands each fetched word plus its PC to decode over valid/ready.
module ifu_fetch #(
    parameter int                   CPU_WIDTH = 32,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = 32'h8000_0000
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic                 ifu_axi_arvalid,
    input  logic                 ifu_axi_arready,
    output logic [CPU_WIDTH-1:0] ifu_axi_araddr,
    output logic [3:0]           ifu_axi_arid,
    output logic [7:0]           ifu_axi_arlen,
    output logic [2:0]           ifu_axi_arsize,
    output logic [1:0]           ifu_axi_arburst,
    input  logic                 ifu_axi_rvalid,
    output logic                 ifu_axi_rready,
    input  logic [CPU_WIDTH-1:0] ifu_axi_rdata,
    input  logic [1:0]           ifu_axi_rresp,
    input  logic                 ifu_axi_rlast,
    input  logic                 redirect_valid,
    input  logic [CPU_WIDTH-1:0] redirect_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CPU_WIDTH-1:0] out_inst,
    output logic [CPU_WIDTH-1:0] out_pc,
    output logic                 out_err
);

    typedef enum logic [1:0] {
        S_AR  = 2'd0,
        S_R   = 2'd1,
        S_OUT = 2'd2
    } state_t;

    localparam logic [CPU_WIDTH-1:0] PC_STEP  = {{(CPU_WIDTH-3){1'b0}}, 3'b100};
    localparam logic [CPU_WIDTH-1:0] RESET_AL = {RESET_PC[CPU_WIDTH-1:2], 2'b00};

    state_t               state_r, state_s;
    logic [CPU_WIDTH-1:0] pc_r, pc_s;
    logic                 drop_r, drop_s;
    logic                 capture_s;
    logic [CPU_WIDTH-1:0] redir_pc_s;
    logic                 ar_hs_s, r_hs_s, out_hs_s;
    logic                 arvalid_r, rready_r, out_valid_r, out_err_r;
    logic [CPU_WIDTH-1:0] araddr_r, out_inst_r, out_pc_r;
    logic                 unused_s;

    // rlast is implied by arlen=0 and the redirect low bits are discarded by alignment
    assign unused_s = ^{ifu_axi_rlast, redirect_pc[1:0]};

    assign redir_pc_s = {redirect_pc[CPU_WIDTH-1:2], 2'b00};
    assign ar_hs_s    = arvalid_r & ifu_axi_arready;
    assign r_hs_s     = rready_r & ifu_axi_rvalid;
    assign out_hs_s   = out_valid_r & out_ready;

    assign ifu_axi_arvalid = arvalid_r;
    assign ifu_axi_araddr  = araddr_r;
    assign ifu_axi_arid    = 4'h0;
    assign ifu_axi_arlen   = 8'h00;
    assign ifu_axi_arsize  = 3'b010;
    assign ifu_axi_arburst = 2'b01;
    assign ifu_axi_rready  = rready_r;
    assign out_valid       = out_valid_r;
    assign out_inst        = out_inst_r;
    assign out_pc          = out_pc_r;
    assign out_err         = out_err_r;

    // Next-state, next-PC and drop-flag logic; redirect outranks every other event
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        drop_s    = drop_r;
        capture_s = 1'b0;
        case (state_r)
            S_AR: begin
                if (redirect_valid) begin
                    pc_s   = redir_pc_s;
                    drop_s = 1'b1;
                end else begin
                    pc_s = pc_r;
                end
                if (ar_hs_s) begin
                    state_s = S_R;
                end else begin
                    state_s = S_AR;
                end
            end
            S_R: begin
                if (redirect_valid) begin
                    pc_s = redir_pc_s;
                    if (r_hs_s) begin
                        drop_s  = 1'b0;
                        state_s = S_AR;
                    end else begin
                        drop_s = 1'b1;
                    end
                end else if (r_hs_s) begin
                    if (drop_r) begin
                        drop_s  = 1'b0;
                        state_s = S_AR;
                    end else begin
                        capture_s = 1'b1;
                        state_s   = S_OUT;
                    end
                end else begin
                    state_s = S_R;
                end
            end
            S_OUT: begin
                if (redirect_valid) begin
                    pc_s    = redir_pc_s;
                    state_s = S_AR;
                end else if (out_hs_s) begin
                    pc_s    = pc_r + PC_STEP;
                    state_s = S_AR;
                end else begin
                    state_s = S_OUT;
                end
            end
            default: begin
                state_s = S_AR;
            end
        endcase
    end

    // State, PC and registered interface outputs; araddr only reloads on entry to S_AR
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= S_AR;
            pc_r        <= RESET_AL;
            drop_r      <= 1'b0;
            arvalid_r   <= 1'b0;
            rready_r    <= 1'b0;
            out_valid_r <= 1'b0;
            araddr_r    <= RESET_AL;
            out_inst_r  <= {CPU_WIDTH{1'b0}};
            out_pc_r    <= {CPU_WIDTH{1'b0}};
            out_err_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            drop_r      <= drop_s;
            arvalid_r   <= (state_s == S_AR);
            rready_r    <= (state_s == S_R);
            out_valid_r <= (state_s == S_OUT);
            if ((state_s == S_AR) && (state_r != S_AR)) begin
                araddr_r <= pc_s;
            end else begin
                araddr_r <= araddr_r;
            end
            if (capture_s) begin
                out_inst_r <= ifu_axi_rdata;
                out_pc_r   <= pc_r;
                out_err_r  <= (ifu_axi_rresp != 2'b00);
            end else begin
                out_inst_r <= out_inst_r;
                out_pc_r   <= out_pc_r;
                out_err_r  <= out_err_r;
            end
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: icache responder model with mem[j]=j, scoreboard of expected
// (pc, inst, err) deliveries, and one task per scenario.
module tb_ifu_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [31:0] araddr, rdata;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, rresp;
    logic        redirect_valid, out_valid, out_ready, out_err;
    logic [31:0] redirect_pc, out_inst, out_pc;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] ar_log[$];
    int          checks = 0;
    int          errors = 0;
    int          n_out  = 0;
    int          ar_stall = 0;
    int          r_delay  = 0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    int          ar_wait;
    bit          r_active;
    int          r_cnt;
    logic [31:0] r_addr;

    always #5 clock = ~clock;

    ifu_fetch #(.CPU_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clock(clock), .reset(reset),
        .ifu_axi_arvalid(arvalid), .ifu_axi_arready(arready), .ifu_axi_araddr(araddr),
        .ifu_axi_arid(arid), .ifu_axi_arlen(arlen), .ifu_axi_arsize(arsize),
        .ifu_axi_arburst(arburst), .ifu_axi_rvalid(rvalid), .ifu_axi_rready(rready),
        .ifu_axi_rdata(rdata), .ifu_axi_rresp(rresp), .ifu_axi_rlast(rlast),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_pc(out_pc), .out_err(out_err)
    );

    // icache responder: decisions made at negedge take effect at the following posedge
    always @(negedge clock) begin
        if (reset) begin
            arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b0;
            ar_wait = 0; r_active = 1'b0; r_cnt = 0; r_addr = 32'h0;
        end else begin
            rvalid = 1'b0; rresp = 2'b00; rlast = 1'b0;
            if (r_active) begin
                if (r_cnt == 0) begin
                    rvalid = 1'b1; rlast = 1'b1; rdata = r_addr >> 2;
                    rresp  = (r_addr == err_addr) ? 2'b10 : 2'b00;
                end else begin
                    r_cnt--;
                end
            end
            if (rvalid && rready) r_active = 1'b0;
            arready = 1'b0;
            if (arvalid) begin
                checks++;
                if (arid !== 4'h0 || arlen !== 8'h00 || arsize !== 3'b010 ||
                    arburst !== 2'b01 || araddr[1:0] !== 2'b00) begin
                    errors++;
                    $display("FAIL ar_attrs: got id=%h len=%h size=%h burst=%h addr=%h, need 0/00/2/1/aligned",
                             arid, arlen, arsize, arburst, araddr);
                end
                if (ar_wait >= ar_stall) arready = 1'b1;
                else ar_wait++;
            end
            if (arvalid && arready) begin
                ar_log.push_back(araddr);
                r_active = 1'b1; r_cnt = r_delay; r_addr = araddr; ar_wait = 0;
            end
        end
    end

    // Scoreboard: a transfer happens at the next posedge when valid&ready and no redirect
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready && !redirect_valid) begin
            n_out++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got pc=%h inst=%h, none expected", out_pc, out_inst);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_pc !== mon_e.pc || out_inst !== mon_e.inst || out_err !== mon_e.err) begin
                    errors++;
                    $display("FAIL out_data: got pc=%h inst=%h err=%b, need pc=%h inst=%h err=%b",
                             out_pc, out_inst, out_err, mon_e.pc, mon_e.inst, mon_e.err);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push_exp(input logic [31:0] pc, input logic err);
        exp_t e;
        e.pc = pc; e.inst = pc >> 2; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        repeat (3) @(posedge clock);
        exp_q.delete(); ar_log.delete(); n_out = 0;
        #1 reset = 1'b0;
    endtask

    // Waits for n_out to reach target, then parks out_ready low so no extra fetch is delivered
    task automatic wait_outs(input int target, output bit ok);
        int cyc = 0;
        ok = 1'b1;
        while (n_out < target) begin
            @(posedge clock);
            cyc++;
            if (cyc > 300) begin ok = 1'b0; break; end
        end
        #1 out_ready = 1'b0;
    endtask

    task automatic wait_level(input bit want_out_valid, output bit ok);
        int cyc = 0;
        ok = 1'b0;
        while (cyc < 100) begin
            @(negedge clock);
            if ((want_out_valid ? out_valid : rready) === 1'b1) begin ok = 1'b1; break; end
            cyc++;
        end
    endtask

    task automatic test_reset();
        out_ready = 1'b1; ar_stall = 0; r_delay = 0; err_addr = 32'hFFFF_FFFF;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({arvalid, rready, out_valid, out_err} !== 4'b0000 || out_inst !== 32'h0 || out_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got arv=%b rr=%b ov=%b err=%b inst=%h pc=%h, need all 0",
                     arvalid, rready, out_valid, out_err, out_inst, out_pc);
        end
        exp_q.delete(); ar_log.delete(); n_out = 0;
        out_ready = 1'b0;
        @(posedge clock); #1 reset = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (arvalid !== 1'b1 || araddr !== 32'h0) begin
            errors++;
            $display("FAIL first_ar: got arvalid=%b araddr=%h, need 1 and 00000000", arvalid, araddr);
        end
    endtask

    task automatic test_sequence();
        bit ok;
        out_ready = 1'b1;
        do_reset();
        push_exp(32'h0, 1'b0); push_exp(32'h4, 1'b0); push_exp(32'h8, 1'b0);
        wait_outs(3, ok);
        checks++;
        if (!ok || exp_q.size() != 0) begin
            errors++;
            $display("FAIL seq_done: got %0d outs, need 3", n_out);
        end
        checks++;
        if (ar_log.size() < 3 || ar_log[0] !== 32'h0 || ar_log[1] !== 32'h4 || ar_log[2] !== 32'h8) begin
            errors++;
            $display("FAIL seq_araddr: got %0d ARs, need 0,4,8", ar_log.size());
        end
    endtask

    task automatic test_ar_stall();
        bit ok;
        out_ready = 1'b1; ar_stall = 5;
        do_reset();
        push_exp(32'h0, 1'b0);
        @(posedge clock);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checks++;
            if (arvalid !== 1'b1 || araddr !== 32'h0) begin
                errors++;
                $display("FAIL ar_stall_hold[%0d]: got arvalid=%b araddr=%h, need 1 and 00000000", i, arvalid, araddr);
            end
        end
        wait_outs(1, ok);
        checks++;
        if (!ok || exp_q.size() != 0) begin
            errors++;
            $display("FAIL ar_stall_done: got %0d outs, need 1", n_out);
        end
        ar_stall = 0;
    endtask

    task automatic test_redirect_r();
        bit ok;
        out_ready = 1'b1; r_delay = 4;
        do_reset();
        push_exp(32'h20, 1'b0);
        wait_level(1'b0, ok);
        @(posedge clock); #1 redirect_valid = 1'b1; redirect_pc = 32'h20;
        @(posedge clock); #1 redirect_valid = 1'b0;
        wait_outs(1, ok);
        checks++;
        if (!ok || exp_q.size() != 0 || ar_log.size() < 2 || ar_log[1] !== 32'h20) begin
            errors++;
            $display("FAIL redirect_r: got %0d outs %0d ARs, need 1 out and second AR at 00000020",
                     n_out, ar_log.size());
        end
        r_delay = 0;
    endtask

    task automatic test_out_stall();
        bit ok;
        out_ready = 1'b1;
        do_reset();
        push_exp(32'h0, 1'b0);
        wait_outs(1, ok);
        push_exp(32'h4, 1'b0);
        wait_level(1'b1, ok);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_inst !== 32'h1 || out_err !== 1'b0 || arvalid !== 1'b0) begin
                errors++;
                $display("FAIL out_stall_hold[%0d]: got ov=%b pc=%h inst=%h arv=%b, need 1/00000004/00000001/0",
                         i, out_valid, out_pc, out_inst, arvalid);
            end
        end
        @(posedge clock); #1 out_ready = 1'b1;
        push_exp(32'h8, 1'b0);
        wait_outs(3, ok);
        checks++;
        if (!ok || ar_log.size() < 3 || ar_log[2] !== 32'h8) begin
            errors++;
            $display("FAIL out_stall_next: got %0d outs %0d ARs, need 3 outs and third AR at 00000008",
                     n_out, ar_log.size());
        end
    endtask

    task automatic test_redirect_out();
        bit ok;
        out_ready = 1'b0;
        do_reset();
        push_exp(32'h10, 1'b0);
        wait_level(1'b1, ok);
        @(posedge clock); #1 out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h13;
        @(posedge clock); #1 redirect_valid = 1'b0;
        wait_outs(1, ok);
        checks++;
        if (!ok || n_out != 1 || ar_log.size() < 2 || ar_log[1] !== 32'h10) begin
            errors++;
            $display("FAIL redirect_out: got %0d outs %0d ARs, need 1 out and second AR at 00000010",
                     n_out, ar_log.size());
        end
    endtask

    task automatic test_err();
        bit ok;
        out_ready = 1'b1; err_addr = 32'h4;
        do_reset();
        push_exp(32'h0, 1'b0); push_exp(32'h4, 1'b1); push_exp(32'h8, 1'b0);
        wait_outs(3, ok);
        checks++;
        if (!ok || exp_q.size() != 0) begin
            errors++;
            $display("FAIL err_done: got %0d outs, need 3", n_out);
        end
        err_addr = 32'hFFFF_FFFF;
    endtask

    task automatic test_back_to_back();
        bit ok;
        out_ready = 1'b1;
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        @(posedge clock); #1 redirect_pc = 32'hFFFF_FFFC;
        @(posedge clock); #1 redirect_valid = 1'b0;
        push_exp(32'hFFFF_FFFC, 1'b0); push_exp(32'h0, 1'b0);
        wait_outs(2, ok);
        checks++;
        if (!ok || exp_q.size() != 0 || ar_log.size() < 3 || ar_log[0] !== 32'h0 ||
            ar_log[1] !== 32'hFFFF_FFFC || ar_log[2] !== 32'h0) begin
            errors++;
            $display("FAIL back_to_back_wrap: got %0d outs %0d ARs, need 2 outs and ARs 0,FFFFFFFC,0",
                     n_out, ar_log.size());
        end
    endtask

    task automatic test_reset_mid_r();
        bit ok;
        out_ready = 1'b1; r_delay = 5;
        do_reset();
        wait_level(1'b0, ok);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (!ok || arvalid !== 1'b0 || rready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_r: got arv=%b rr=%b ov=%b, need 0/0/0", arvalid, rready, out_valid);
        end
        repeat (2) @(posedge clock);
        exp_q.delete(); ar_log.delete(); n_out = 0; r_delay = 0;
        push_exp(32'h0, 1'b0);
        #1 reset = 1'b0;
        wait_outs(1, ok);
        checks++;
        if (!ok || exp_q.size() != 0 || ar_log.size() < 1 || ar_log[0] !== 32'h0) begin
            errors++;
            $display("FAIL reset_restart: got %0d outs %0d ARs, need fetch from 00000000", n_out, ar_log.size());
        end
    endtask

    initial begin
        reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        test_reset();
        test_sequence();
        test_ar_stall();
        test_redirect_r();
        test_out_stall();
        test_redirect_out();
        test_err();
        test_back_to_back();
        test_reset_mid_r();
        repeat (3) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction-fetch front end sitting directly upstream of axi_icache.
- Holds the PC and issues single-beat AXI read requests (one outstanding at a time) to the icache's ifu_* slave port.
- Delivers each fetched instruction plus its PC to the decode stage over a valid/ready handshake.
- Accepts redirects (branch/jump/trap) at any time and discards any response already in flight.

Parameters:
- CPU_WIDTH, 32, data and address width; matches `CPU_WIDTH.
- RESET_PC, 32'h8000_0000, PC loaded on reset.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ifu_axi_arvalid  out  1  AR valid to icache
- ifu_axi_arready  in  1  AR ready from icache
- ifu_axi_araddr  out  CPU_WIDTH  fetch address, always word-aligned
- ifu_axi_arid  out  4  constant 4'h0
- ifu_axi_arlen  out  8  constant 8'h00
- ifu_axi_arsize  out  3  constant 3'b010
- ifu_axi_arburst  out  2  constant 2'b01 (INCR)
- ifu_axi_rvalid  in  1  R valid from icache
- ifu_axi_rready  out  1  R ready to icache
- ifu_axi_rdata  in  CPU_WIDTH  instruction word
- ifu_axi_rresp  in  2  response code
- ifu_axi_rlast  in  1  last beat; always 1 for arlen=0, not checked
- redirect_valid  in  1  redirect request
- redirect_pc  in  CPU_WIDTH  redirect target; bits [1:0] forced to 0
- out_valid  out  1  instruction valid to decode
- out_ready  in  1  decode ready
- out_inst  out  CPU_WIDTH  instruction
- out_pc  out  CPU_WIDTH  PC of out_inst
- out_err  out  1  1 if rresp != 2'b00 for this fetch

Write channels (AW/W/B) are not part of this block; integration ties awvalid=0, wvalid=0, bready=0.

Behaviour:
- Reset (asynchronous, active-high): state=S_AR, pc=RESET_PC, drop=0. Outputs while reset is asserted: arvalid=0, rready=0, out_valid=0, out_inst=0, out_pc=0, out_err=0.
- First arvalid is asserted in the first cycle after reset deasserts.

State machine:
- S_AR
  - arvalid=1, araddr={pc[31:2],2'b00}.
  - araddr must stay stable while arvalid=1 and arready=0 (AXI rule); a redirect never changes araddr mid-handshake.
  - On arvalid&&arready: go to S_R.
- S_R
  - rready=1.
  - On rvalid with drop=1: discard data, clear drop, go to S_AR (pc already holds the redirect target).
  - On rvalid with drop=0: latch out_inst=rdata, out_pc=pc, out_err=(rresp!=0); go to S_OUT.
- S_OUT
  - out_valid=1; outputs held stable until accepted.
  - On out_ready (no redirect): pc<=pc+4 with 32-bit wrap (0xFFFF_FFFC -> 0x0); go to S_AR.

Redirect rules (redirect_valid=1 takes priority over every other event in the same cycle):
- In S_AR: pc<=redirect_pc and drop<=1. The current AR is still completed with the old araddr, and its response is discarded.
- In S_R without rvalid: pc<=redirect_pc, drop<=1.
- In S_R with rvalid in the same cycle: the data is discarded, pc<=redirect_pc, drop stays 0, go to S_AR.
- In S_OUT: the instruction is squashed even if out_ready=1 (no transfer counts); pc<=redirect_pc; go to S_AR.
- Back-to-back redirects: the last target wins; drop remains a single bit because only one transaction is ever outstanding.

Throughput and latency:
- Minimum 3 cycles per instruction: AR, R, OUT.
- No new AR is issued while out_valid=1 is pending.

Test Plan:
- RESET_PC=0, icache over axi_ram with mem[j]=j, out_ready=1 -> out sequence (pc,inst) = (0x0,0), (0x4,1), (0x8,2); araddr sequence 0x0, 0x4, 0x8; arlen=0, arsize=2, arburst=1 throughout.
- arready held low for 5 cycles after the first arvalid -> araddr stays 0x0 and arvalid stays 1 across all 5 cycles; fetch then completes with inst=0.
- redirect_valid pulse to 0x20 while in S_R (rvalid delayed) -> returned word for 0x0 is dropped; next out is (pc=0x20, inst=8); no out_valid for the 0x0 fetch.
- out_ready=0 for 4 cycles in S_OUT with out=(0x4,1) -> outputs stable, no AR issued; then out_ready=1 -> next araddr=0x8.
- redirect to 0x13 in S_OUT coincident with out_ready=1 -> no transfer counted; next araddr=0x10 (low bits forced to 0).
- rresp=2'b10 injected on the 0x4 fetch -> out_err=1 with out_pc=0x4; next fetch has out_err=0. Assert reset mid-S_R -> arvalid/rready/out_valid drop to 0 immediately; after release, fetch restarts at RESET_PC.
